load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator on the data port of the unified word-addressed memory (12-bit line, 32-bit word, combinational read, posedge write).
- Converts CPU byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into line accesses.
- Sub-word stores use read-modify-write.
- Sits between the core's execute stage and the memory; the instruction port is not touched.

Parameters:
LINE_WIDTH, 12, width of memory line index; the addressable range is 2^(LINE_WIDTH+2) bytes.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  LSU can accept a request (IDLE only)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (size/sign)
req_addr  input  32  byte address
req_wdata  input  32  store data (low bytes used for SB/SH)
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and faults
resp_fault  output  1  misaligned, out-of-range or illegal funct3; qualified by resp_valid
mem_line  output  LINE_WIDTH  memory line index = addr[LINE_WIDTH+1:2]
mem_write_data  output  32  word to write
mem_write  output  1  write strobe, sampled by memory at posedge
mem_data  input  32  combinational read data for mem_line

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_write=0, mem_line=0, mem_write_data=0, all latches 0.
- States: IDLE, LOAD, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, funct3, wdata and write.
  - Classify:
    - fault → RESP with fault=1; no memory access.
    - load → LOAD.
    - SW → WRITE.
    - SB/SH → READ.
- Fault conditions (any one):
  - addr[31:LINE_WIDTH+2] != 0.
  - Half access with addr[0] != 0.
  - Word access with addr[1:0] != 0.
  - Load funct3 in {3,6,7}.
  - Store funct3 not in {0,1,2}.
- LOAD:
  - mem_line = latched line.
  - Select byte addr[1:0] or half addr[1].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register into resp_rdata → RESP.
- READ: capture mem_data into merge register → WRITE.
- WRITE:
  - mem_write = 1 for exactly this cycle, gated combinationally by !reset.
  - mem_write_data is the merge register with the selected byte/half replaced, or the full wdata for SW.
  - Unselected bytes are unchanged.
  - → RESP.
- RESP: resp_valid=1 for one cycle, with resp_rdata/resp_fault valid → IDLE. req_ready=0.
- Latency (from the accept edge T; resp_valid high in the cycle after that edge):
  - load: resp_valid in cycle T+2.
  - SW: mem_write in T+1, resp in T+2.
  - SB/SH: mem_write in T+2, resp in T+3.
  - fault: resp in T+1.
- Outside LOAD/READ/WRITE: mem_line holds the last latched line, mem_write=0.
- req_ready is 0 in every non-IDLE state. Requests presented then are ignored; the CPU must hold them.
- Reset mid-operation:
  - Return to IDLE at that edge.
  - A WRITE cycle coinciding with reset must not modify memory.
  - No resp_valid is produced for the aborted request.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after RESP.

Test Plan:
- Memory line 1 = 0x8000_00F0; LB addr 0x4 → resp_rdata 0xFFFF_FFF0 at T+2. LBU → 0x0000_00F0. LH addr 0x6 → 0xFFFF_8000.
- Line 2 = 0x1122_3344; SB addr 0x9, wdata 0xAB → single mem_write at T+2 with data 0x1122_AB44, resp_valid at T+3, fault=0.
- SW addr 0xC, wdata 0xDEAD_BEEF → mem_write at T+1, line 3 = 0xDEAD_BEEF; subsequent LW addr 0xC returns 0xDEAD_BEEF.
- Fault cases → resp_fault=1 at T+1, no mem_write pulse at any cycle, resp_rdata=0:
  - LH addr 0x3;
  - LW addr 0x2;
  - SW addr 0x0001_0000 (LINE_WIDTH=12);
  - load funct3=3.
- SH addr 0x2, wdata 0x5566, with reset asserted during the WRITE cycle → line 0 unchanged, no resp_valid, state IDLE with req_ready=1 next cycle.
- Hold req_valid high continuously with alternating LW/SW → exactly one accept per transaction, req_ready low between accept and RESP, responses in request order.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed CPU loads/stores into accesses on a
// word-addressed memory line port, using read-modify-write for SB/SH.
module load_store_unit #(
    parameter int LINE_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [LINE_WIDTH-1:0] mem_line,
    output logic [31:0]           mem_write_data,
    output logic                  mem_write,
    input  logic [31:0]           mem_data
);

    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [LINE_WIDTH+1:0]   addr_reg;
    logic [2:0]              funct3_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             merge_reg;
    logic [31:0]             rdata_reg;
    logic                    fault_reg;

    logic                    addr_oob, misaligned, bad_funct3, req_fault;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic [31:0]             load_value;
    logic [3:0]              lane_sel;
    logic [31:0]             store_data;
    logic [31:0]             merged;

    // Request classification works on the live request so the accept edge can branch directly.
    assign addr_oob   = |req_addr[31:LINE_WIDTH+2];
    assign misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'd2 && |req_addr[1:0]);
    assign bad_funct3 = req_write ? (req_funct3 > 3'd2)
                                  : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
    assign req_fault  = addr_oob || misaligned || bad_funct3;

    assign mem_line   = addr_reg[LINE_WIDTH+1:2];
    assign resp_rdata = rdata_reg;
    assign resp_fault = fault_reg;

    assign load_byte = mem_data[{addr_reg[1:0], 3'b000} +: 8];
    assign load_half = addr_reg[1] ? mem_data[31:16] : mem_data[15:0];

    always_comb begin
        case (funct3_reg)
            3'd0:    load_value = {{24{load_byte[7]}}, load_byte};
            3'd1:    load_value = {{16{load_half[15]}}, load_half};
            3'd4:    load_value = {24'd0, load_byte};
            3'd5:    load_value = {16'd0, load_half};
            default: load_value = mem_data;
        endcase
    end

    // Each byte lane either takes the replicated store data or keeps the merge register byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_sel[gi] = (funct3_reg[1:0] == 2'd2) ||
                                  (funct3_reg[1:0] == 2'd1 && addr_reg[1] == 1'(gi / 2)) ||
                                  (funct3_reg[1:0] == 2'd0 && addr_reg[1:0] == 2'(gi));
            assign store_data[8*gi +: 8] = (funct3_reg[1:0] == 2'd0) ? wdata_reg[7:0] :
                                           (funct3_reg[1:0] == 2'd1) ? wdata_reg[8*(gi%2) +: 8] :
                                                                       wdata_reg[8*gi +: 8];
            assign merged[8*gi +: 8] = lane_sel[gi] ? store_data[8*gi +: 8] : merge_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = 32'd0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault)                     state_next = RESP;
                    else if (!req_write)               state_next = LOAD;
                    else if (req_funct3[1:0] == 2'd2)  state_next = WRITE;
                    else                               state_next = READ;
                end
            end
            LOAD:  state_next = RESP;
            READ:  state_next = WRITE;
            WRITE: begin
                // Gated by reset so an aborted store never reaches memory.
                mem_write      = !reset;
                mem_write_data = merged;
                state_next     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            funct3_reg <= 3'd0;
            wdata_reg  <= 32'd0;
            merge_reg  <= 32'd0;
            rdata_reg  <= 32'd0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg   <= req_addr[LINE_WIDTH+1:0];
                        funct3_reg <= req_funct3;
                        wdata_reg  <= req_wdata;
                        rdata_reg  <= 32'd0;
                        fault_reg  <= req_fault;
                    end
                end
                LOAD:    rdata_reg <= load_value;
                READ:    merge_reg <= mem_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, scoreboard queue filled at
// accept time and drained by a monitor on resp_valid.
module tb_load_store_unit;

    localparam int LW = 12;
    localparam int NLINES = 1 << LW;
    localparam int NBYTES = 1 << (LW + 2);

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic [LW-1:0] mem_line;
    logic [31:0]   mem_write_data;
    logic          mem_write;
    logic [31:0]   mem_data;

    load_store_unit #(.LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_line(mem_line), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory seen by the DUT, and the reference model's own byte-addressed view.
    logic [31:0] mem [0:NLINES-1];
    logic [7:0]  ref_mem [0:NBYTES-1];
    assign mem_data = mem[mem_line];

    typedef struct {
        logic [31:0] rd;
        logic        flt;
        int          lat;
        int          nwr;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int n_resp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int line);
        return {ref_mem[4*line+3], ref_mem[4*line+2], ref_mem[4*line+1], ref_mem[4*line]};
    endfunction

    task automatic set_word(input int line, input logic [31:0] w);
        mem[line] = w;
        for (int i = 0; i < 4; i++) ref_mem[4*line+i] = w[8*i +: 8];
    endtask

    // Reference behaviour straight from the RV32I rules: size, alignment, range, extension.
    task automatic ref_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output exp_t e);
        int size;
        logic [31:0] val;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.rd = 32'd0; e.flt = 1'b0; e.lat = 1; e.nwr = 0; e.acc = cyc;
        if (a >= NBYTES || (a % size) != 0 || (w ? (f3 > 2) : (f3 == 3 || f3 >= 6))) begin
            e.flt = 1'b1;
        end else if (w) begin
            for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
            e.lat = (size == 4) ? 2 : 3;
            e.nwr = 1;
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++) val = val | (32'(ref_mem[a+i]) << (8*i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
            e.rd  = val;
            e.lat = 2;
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit track);
        exp_t e;
        int n;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            if (track) begin
                ref_txn(w, f3, a, wd, e);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor_step();
        exp_t e;
        if (mem_write) wr_cnt++;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                n_resp++;
                $display("[TB] resp %0d: rdata=%h fault=%0d latency=%0d writes=%0d",
                         n_resp, resp_rdata, resp_fault, cyc - e.acc, wr_cnt);
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_fault", 32'(resp_fault), 32'(e.flt));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("write_pulses", 32'(wr_cnt), 32'(e.nwr));
            end
            wr_cnt = 0;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        w;
        int          n, bad;
        logic        pw;
        logic [LW-1:0] pl;
        logic [31:0] pd;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < NLINES; i++) set_word(i, $urandom);
        set_word(1, 32'h8000_00F0);
        set_word(2, 32'h1122_3344);

        // Memory model: write strobe sampled away from the edge, applied at the posedge.
        fork
            forever begin
                @(negedge clk);
                pw = mem_write; pl = mem_line; pd = mem_write_data;
                @(posedge clk);
                if (pw) mem[pl] = pd;
            end
            forever begin
                @(negedge clk);
                monitor_step();
            end
            begin
                #300000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_line", 32'(mem_line), 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        @(posedge clk); #1;

        // Directed loads, sub-word store, word store/readback.
        issue(0, 3'd0, 32'h4, 32'd0, 1); idle(0);
        issue(0, 3'd4, 32'h4, 32'd0, 1); idle(0);
        issue(0, 3'd1, 32'h6, 32'd0, 1); idle(3);
        issue(1, 3'd0, 32'h9, 32'h0000_00AB, 1); idle(4);
        chk("sb_line2", mem[2], 32'h1122_AB44);
        issue(1, 3'd2, 32'hC, 32'hDEAD_BEEF, 1); idle(3);
        chk("sw_line3", mem[3], 32'hDEAD_BEEF);
        issue(0, 3'd2, 32'hC, 32'd0, 1); idle(3);

        // Faults: misaligned half/word, out of range, illegal load funct3.
        issue(0, 3'd1, 32'h3, 32'd0, 1); idle(2);
        issue(0, 3'd2, 32'h2, 32'd0, 1); idle(2);
        issue(1, 3'd2, 32'h0001_0000, 32'h1234_5678, 1); idle(2);
        issue(0, 3'd3, 32'h0, 32'd0, 1); idle(2);

        // SH aborted by reset during its WRITE cycle.
        issue(1, 3'd1, 32'h2, 32'h0000_5566, 0);
        req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        idle(3);
        chk("abort_line0", mem[0], ref_word(0));

        // req_valid held high across alternating LW/SW requests.
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            issue(i[0], 3'd2, a, $urandom, 1);
        end
        idle(3);

        // Randomised mix, mostly in a small line window to force reuse.
        for (int i = 0; i < 300; i++) begin
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else                            a = 32'($urandom_range(0, 63));
            issue(w, f3, a, $urandom, 1);
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        idle(3);

        bad = 0;
        for (int i = 0; i < NLINES; i++) if (mem[i] !== ref_word(i)) bad++;
        chk("final_memory_mismatches", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
